// File: rtl/swd_xfer_sequencer_if.sv
// Command/response bundle between the MCU side and the SWD transfer sequencer.
interface swd_xfer_sequencer_if #(
    parameter int RETRY_W = 4
);
    logic               cmd_valid;
    logic               cmd_ready;
    logic               cmd_apndp;
    logic               cmd_rnw;
    logic [1:0]         cmd_addr;
    logic [31:0]        cmd_wdata;
    logic               abort;
    logic               rsp_valid;
    logic [2:0]         rsp_ack;
    logic [31:0]        rsp_rdata;
    logic               rsp_perr;
    logic [RETRY_W-1:0] rsp_retries;

    modport master (
        output cmd_valid, cmd_apndp, cmd_rnw, cmd_addr, cmd_wdata, abort,
        input  cmd_ready, rsp_valid, rsp_ack, rsp_rdata, rsp_perr, rsp_retries
    );

    modport slave (
        input  cmd_valid, cmd_apndp, cmd_rnw, cmd_addr, cmd_wdata, abort,
        output cmd_ready, rsp_valid, rsp_ack, rsp_rdata, rsp_perr, rsp_retries
    );
endinterface

// File: rtl/swd_xfer_sequencer.sv
// SWD transaction sequencer: builds 48-bit DP/AP frames for the frontend,
// samples ACK/read data, retries on WAIT and returns one response per command.
module swd_xfer_sequencer #(
    parameter int GAP_CYCLES = 4,
    parameter int MAX_RETRY  = 8,
    parameter int RETRY_W    = 4
) (
    input  logic                 sck,
    input  logic                 rst,
    swd_xfer_sequencer_if.slave  bus,
    output logic                 fe_frame_en,
    output logic                 fe_rnw,
    output logic                 fe_mosi,
    input  logic                 fe_miso
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] GAP   = 2'd1;
    localparam logic [1:0] FRAME = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam logic [GW-1:0]      GAP_LAST  = GW'(GAP_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);
    localparam logic [2:0]         ACK_OK    = 3'b001;
    localparam logic [2:0]         ACK_WAIT  = 3'b010;

    logic [1:0]         state;
    logic [GW-1:0]      gap_cnt;
    logic [5:0]         bit_idx;
    logic               apndp;
    logic [1:0]         addr;
    logic [31:0]        wdata;
    logic [2:0]         ack_q;
    logic [31:0]        rdata_q;
    logic [RETRY_W-1:0] retries;
    logic [7:0]         req;
    logic [2:0]         ack_now;

    // Request byte, index 0 goes on the wire first
    assign req = {1'b1, 1'b0, ^{apndp, fe_rnw, addr},
                  addr[1], addr[0], fe_rnw, apndp, 1'b1};
    assign ack_now = {fe_miso, ack_q[1:0]};

    assign bus.cmd_ready = (state == IDLE);
    assign bus.rsp_valid = (state == RESP);
    assign fe_frame_en   = (state == FRAME);

    always_comb begin
        fe_mosi = 1'b0;
        if (state == FRAME) begin
            unique case (1'b1)
                (bit_idx >= 6'd3 && bit_idx <= 6'd10):
                    fe_mosi = req[3'(bit_idx - 6'd3)];
                (bit_idx >= 6'd15 && bit_idx <= 6'd46):
                    fe_mosi = ~fe_rnw & wdata[5'(bit_idx - 6'd15)];
                (bit_idx == 6'd47):
                    fe_mosi = ~fe_rnw & ~^wdata;
                default:
                    fe_mosi = 1'b0;
            endcase
        end
    end

    always_ff @(posedge sck) begin
        if (rst) begin
            state           <= IDLE;
            gap_cnt         <= '0;
            bit_idx         <= '0;
            apndp           <= 1'b0;
            fe_rnw          <= 1'b0;
            addr            <= '0;
            wdata           <= '0;
            ack_q           <= '0;
            rdata_q         <= '0;
            retries         <= '0;
            bus.rsp_ack     <= '0;
            bus.rsp_rdata   <= '0;
            bus.rsp_perr    <= 1'b0;
            bus.rsp_retries <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        apndp   <= bus.cmd_apndp;
                        fe_rnw  <= bus.cmd_rnw;
                        addr    <= bus.cmd_addr;
                        wdata   <= bus.cmd_wdata;
                        retries <= '0;
                        gap_cnt <= '0;
                        state   <= GAP;
                    end
                end
                GAP: begin
                    // A nonzero retry count marks this gap as a WAIT retry
                    if (bus.abort && retries != '0) begin
                        state           <= RESP;
                        bus.rsp_ack     <= ack_q;
                        bus.rsp_rdata   <= '0;
                        bus.rsp_perr    <= 1'b0;
                        bus.rsp_retries <= retries;
                    end else if (gap_cnt == GAP_LAST) begin
                        state   <= FRAME;
                        bit_idx <= '0;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                FRAME: begin
                    bit_idx <= bit_idx + 6'd1;
                    unique case (1'b1)
                        (bit_idx == 6'd12): ack_q[0] <= fe_miso;
                        (bit_idx == 6'd13): ack_q[1] <= fe_miso;
                        (bit_idx == 6'd14): begin
                            ack_q[2] <= fe_miso;
                            if (ack_now != ACK_OK) begin
                                if (ack_now == ACK_WAIT &&
                                    retries < RETRY_MAX && !bus.abort) begin
                                    retries <= retries + 1'b1;
                                    gap_cnt <= '0;
                                    state   <= GAP;
                                end else begin
                                    state           <= RESP;
                                    bus.rsp_ack     <= ack_now;
                                    bus.rsp_rdata   <= '0;
                                    bus.rsp_perr    <= 1'b0;
                                    bus.rsp_retries <= retries;
                                end
                            end
                        end
                        (bit_idx >= 6'd15 && bit_idx <= 6'd46):
                            rdata_q[5'(bit_idx - 6'd15)] <= fe_miso;
                        (bit_idx == 6'd47): begin
                            state           <= RESP;
                            bus.rsp_ack     <= ack_q;
                            bus.rsp_rdata   <= fe_rnw ? rdata_q : 32'd0;
                            bus.rsp_perr    <= fe_rnw & (^rdata_q ^ fe_miso);
                            bus.rsp_retries <= retries;
                        end
                        default: ;
                    endcase
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
